// File: rtl/roce_stack_pkg.sv
// Shared RoCE stack types: DataMover command layout and the command-gate meta entry.
// Field order follows the 104-bit DataMover command word, MSB first.
package roce_stack_pkg;

   localparam int unsigned DM_CMD_W = 104;
   localparam int unsigned DM_BTT_W = 23;

   typedef struct packed {
      logic [7:0]          rsvd;
      logic [63:0]         addr;
      logic                drr;
      logic                eof;
      logic [5:0]          dsa;
      logic                cmd_type;
      logic [DM_BTT_W-1:0] btt;
   } dm_cmd_t;

   typedef struct packed {
      logic                bad;
      logic [DM_BTT_W-1:0] btt;
   } gate_meta_t;

   typedef enum logic [1:0] {
      D_IDLE,
      D_PASS,
      D_ERR
   } gate_state_e;

endpackage

// File: rtl/roce_stack_dma_cmd_gate_if.sv
// Command, DataMover command and payload channels of the DMA command gate.
// Signal names are seen from the gate.
interface roce_stack_dma_cmd_gate_if #(
   parameter int unsigned DATA_W = 512
);
   import roce_stack_pkg::*;

   localparam int unsigned BYTES = DATA_W / 8;

   logic                cmd_valid_i;
   logic                cmd_ready_o;
   logic [DM_CMD_W-1:0] cmd_data_i;
   logic                err_st_i;

   logic                m_cmd_valid_o;
   logic                m_cmd_ready_i;
   logic [DM_CMD_W-1:0] m_cmd_data_o;

   logic                src_tvalid_i;
   logic                src_tready_o;
   logic [DATA_W-1:0]   src_tdata_i;
   logic [BYTES-1:0]    src_tkeep_i;
   logic                src_tlast_i;

   logic                dst_tvalid_o;
   logic                dst_tready_i;
   logic [DATA_W-1:0]   dst_tdata_o;
   logic [BYTES-1:0]    dst_tkeep_o;
   logic                dst_tlast_o;

   modport slave (
      input  cmd_valid_i, cmd_data_i, err_st_i, m_cmd_ready_i,
             src_tvalid_i, src_tdata_i, src_tkeep_i, src_tlast_i, dst_tready_i,
      output cmd_ready_o, m_cmd_valid_o, m_cmd_data_o, src_tready_o,
             dst_tvalid_o, dst_tdata_o, dst_tkeep_o, dst_tlast_o
   );

   modport master (
      output cmd_valid_i, cmd_data_i, err_st_i, m_cmd_ready_i,
             src_tvalid_i, src_tdata_i, src_tkeep_i, src_tlast_i, dst_tready_i,
      input  cmd_ready_o, m_cmd_valid_o, m_cmd_data_o, src_tready_o,
             dst_tvalid_o, dst_tdata_o, dst_tkeep_o, dst_tlast_o
   );

endinterface

// File: rtl/roce_stack_cmd_meta_fifo.sv
// First-word-fall-through FIFO of outstanding command meta entries.
// A push while full is accepted only together with a pop.
module roce_stack_cmd_meta_fifo
   import roce_stack_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       push_i,
   input  gate_meta_t push_data_i,
   input  logic       pop_i,
   output gate_meta_t head_o,
   output logic       full_o,
   output logic       empty_o
);

   localparam int unsigned AW = $clog2(DEPTH);

   gate_meta_t    mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;
   logic          wr_en;
   logic          rd_en;

   assign full_o  = (count == (AW+1)'(DEPTH));
   assign empty_o = (count == '0);
   assign head_o  = mem[rd_ptr];
   assign rd_en   = pop_i && !empty_o;
   assign wr_en   = push_i && (!full_o || rd_en);

   always_ff @(posedge clk_i) begin
      if (wr_en) begin
         mem[wr_ptr] <= push_data_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_en) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (rd_en) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         unique case ({wr_en, rd_en})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/roce_stack_dma_cmd_gate.sv
// Gates errored DMA commands away from the DataMover while keeping the payload
// stream aligned: zero-fill toward the stack (READ=1) or drain from it (READ=0).
module roce_stack_dma_cmd_gate
   import roce_stack_pkg::*;
#(
   parameter int unsigned READ      = 1,
   parameter int unsigned DATA_W    = 512,
   parameter int unsigned CMD_DEPTH = 4
) (
   input  logic                             clk_i,
   input  logic                             rst_i,
   roce_stack_dma_cmd_gate_if.slave         bus,
   output logic [15:0]                      err_cnt_o,
   output logic                             len_mismatch_o
);

   localparam int unsigned BYTES = DATA_W / 8;
   localparam int unsigned LB    = $clog2(BYTES);

   typedef logic [BYTES-1:0]    keep_t;
   typedef logic [DM_BTT_W-1:0] btt_t;

   function automatic btt_t beats_of(btt_t btt);
      btt_t sum;
      sum = btt + btt_t'(BYTES - 1);
      return sum >> LB;
   endfunction

   function automatic keep_t keep_of(btt_t btt);
      logic [LB-1:0] rem;
      rem = btt[LB-1:0];
      if (rem == '0) begin
         return '1;
      end
      return (keep_t'(1) << rem) - keep_t'(1);
   endfunction

   dm_cmd_t     cmd_in;
   logic        cmd_bad;
   logic        cmd_hs;
   dm_cmd_t     m_cmd_q;
   logic        m_cmd_valid_q;

   gate_meta_t  head;
   logic        fifo_full;
   logic        fifo_empty;
   logic        pop;

   gate_state_e state;
   btt_t        beat_cnt;
   keep_t       last_keep;
   logic        is_last;
   logic        beat_hs;
   logic        src_hs;

   logic        src_tready;
   logic        dst_tvalid;
   logic [DATA_W-1:0] dst_tdata;
   keep_t       dst_tkeep;
   logic        dst_tlast;

   assign cmd_in         = dm_cmd_t'(bus.cmd_data_i);
   assign cmd_bad        = bus.err_st_i || (cmd_in.btt == '0);
   assign bus.cmd_ready_o = !fifo_full && (!m_cmd_valid_q || bus.m_cmd_ready_i);
   assign cmd_hs         = bus.cmd_valid_i && bus.cmd_ready_o;

   assign bus.m_cmd_valid_o = m_cmd_valid_q;
   assign bus.m_cmd_data_o  = m_cmd_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         m_cmd_valid_q <= 1'b0;
         m_cmd_q       <= '0;
         err_cnt_o     <= '0;
      end else begin
         if (m_cmd_valid_q && bus.m_cmd_ready_i) begin
            m_cmd_valid_q <= 1'b0;
         end
         if (cmd_hs && !cmd_bad) begin
            m_cmd_valid_q <= 1'b1;
            m_cmd_q       <= cmd_in;
         end
         if (cmd_hs && cmd_bad && (err_cnt_o != '1)) begin
            err_cnt_o <= err_cnt_o + 16'd1;
         end
      end
   end

   roce_stack_cmd_meta_fifo #(
      .DEPTH (CMD_DEPTH)
   ) u_meta_fifo (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .push_i      (cmd_hs),
      .push_data_i ('{bad: cmd_bad, btt: cmd_in.btt}),
      .pop_i       (pop),
      .head_o      (head),
      .full_o      (fifo_full),
      .empty_o     (fifo_empty)
   );

   assign is_last = (beat_cnt == btt_t'(1));

   // Errored zero-length entries never leave D_IDLE; they retire straight from the head.
   assign pop = (state == D_IDLE && !fifo_empty && head.bad && head.btt == '0)
             || (beat_hs && is_last);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state     <= D_IDLE;
         beat_cnt  <= '0;
         last_keep <= '1;
      end else begin
         unique case (state)
            D_IDLE: begin
               if (!fifo_empty) begin
                  beat_cnt  <= beats_of(head.btt);
                  last_keep <= keep_of(head.btt);
                  if (!head.bad) begin
                     state <= D_PASS;
                  end else if (head.btt != '0) begin
                     state <= D_ERR;
                  end
               end
            end
            D_PASS, D_ERR: begin
               if (beat_hs) begin
                  beat_cnt <= beat_cnt - btt_t'(1);
                  if (is_last) begin
                     state <= D_IDLE;
                  end
               end
            end
            default: state <= D_IDLE;
         endcase
      end
   end

   always_comb begin
      src_tready = 1'b0;
      dst_tvalid = 1'b0;
      dst_tdata  = '0;
      dst_tkeep  = '0;
      dst_tlast  = 1'b0;
      beat_hs    = 1'b0;
      unique case (state)
         D_PASS: begin
            dst_tvalid = bus.src_tvalid_i;
            src_tready = bus.dst_tready_i;
            dst_tdata  = bus.src_tdata_i;
            dst_tkeep  = bus.src_tkeep_i;
            dst_tlast  = is_last;
            beat_hs    = bus.src_tvalid_i && bus.dst_tready_i;
         end
         D_ERR: begin
            if (READ != 0) begin
               dst_tvalid = 1'b1;
               dst_tkeep  = is_last ? last_keep : '1;
               dst_tlast  = is_last;
               beat_hs    = bus.dst_tready_i;
            end else begin
               src_tready = 1'b1;
               beat_hs    = bus.src_tvalid_i;
            end
         end
         default: ;
      endcase
   end

   assign bus.src_tready_o = src_tready;
   assign bus.dst_tvalid_o = dst_tvalid;
   assign bus.dst_tdata_o  = dst_tdata;
   assign bus.dst_tkeep_o  = dst_tkeep;
   assign bus.dst_tlast_o  = dst_tlast;

   assign src_hs = bus.src_tvalid_i && src_tready;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         len_mismatch_o <= 1'b0;
      end else if (src_hs && (bus.src_tlast_i != is_last)) begin
         len_mismatch_o <= 1'b1;
      end
   end

endmodule

// File: tb/tb_roce_stack_dma_cmd_gate.sv
// Bench for roce_stack_dma_cmd_gate: a READ=1 and a READ=0 instance share one
// stimulus engine; expected command and beat streams come from a per-command model.
module tb_roce_stack_dma_cmd_gate;
   import roce_stack_pkg::*;

   localparam int unsigned DATA_W = 512;
   localparam int unsigned BYTES  = 64;

   typedef struct {
      logic [DATA_W-1:0] data;
      logic [BYTES-1:0]  keep;
      logic              last;
   } beat_t;

   typedef struct {
      logic                err;
      logic                bad;
      logic [DM_CMD_W-1:0] data;
   } cmd_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic                mode = 1'b1;
   logic                cmd_valid = 1'b0;
   logic [DM_CMD_W-1:0] cmd_data = '0;
   logic                err_st = 1'b0;
   logic                m_cmd_ready = 1'b0;
   logic                src_tvalid = 1'b0;
   logic [DATA_W-1:0]   src_tdata = '0;
   logic [BYTES-1:0]    src_tkeep = '0;
   logic                src_tlast = 1'b0;
   logic                dst_tready = 1'b0;

   roce_stack_dma_cmd_gate_if #(.DATA_W(DATA_W)) if_rd ();
   roce_stack_dma_cmd_gate_if #(.DATA_W(DATA_W)) if_wr ();

   logic [15:0] err_cnt_rd, err_cnt_wr;
   logic        lm_rd, lm_wr;

   roce_stack_dma_cmd_gate #(.READ(1), .DATA_W(DATA_W), .CMD_DEPTH(4)) dut_rd (
      .clk_i(clk), .rst_i(rst), .bus(if_rd), .err_cnt_o(err_cnt_rd), .len_mismatch_o(lm_rd));
   roce_stack_dma_cmd_gate #(.READ(0), .DATA_W(DATA_W), .CMD_DEPTH(4)) dut_wr (
      .clk_i(clk), .rst_i(rst), .bus(if_wr), .err_cnt_o(err_cnt_wr), .len_mismatch_o(lm_wr));

   assign if_rd.cmd_valid_i   = mode & cmd_valid;
   assign if_rd.cmd_data_i    = cmd_data;
   assign if_rd.err_st_i      = err_st;
   assign if_rd.m_cmd_ready_i = mode & m_cmd_ready;
   assign if_rd.src_tvalid_i  = mode & src_tvalid;
   assign if_rd.src_tdata_i   = src_tdata;
   assign if_rd.src_tkeep_i   = src_tkeep;
   assign if_rd.src_tlast_i   = src_tlast;
   assign if_rd.dst_tready_i  = mode & dst_tready;

   assign if_wr.cmd_valid_i   = !mode & cmd_valid;
   assign if_wr.cmd_data_i    = cmd_data;
   assign if_wr.err_st_i      = err_st;
   assign if_wr.m_cmd_ready_i = !mode & m_cmd_ready;
   assign if_wr.src_tvalid_i  = !mode & src_tvalid;
   assign if_wr.src_tdata_i   = src_tdata;
   assign if_wr.src_tkeep_i   = src_tkeep;
   assign if_wr.src_tlast_i   = src_tlast;
   assign if_wr.dst_tready_i  = !mode & dst_tready;

   logic                o_cmd_ready, o_m_cmd_valid, o_src_tready, o_dst_tvalid, o_dst_tlast, o_lm;
   logic [DM_CMD_W-1:0] o_m_cmd_data;
   logic [DATA_W-1:0]   o_dst_tdata;
   logic [BYTES-1:0]    o_dst_tkeep;
   logic [15:0]         o_err_cnt;

   assign o_cmd_ready   = mode ? if_rd.cmd_ready_o   : if_wr.cmd_ready_o;
   assign o_m_cmd_valid = mode ? if_rd.m_cmd_valid_o : if_wr.m_cmd_valid_o;
   assign o_m_cmd_data  = mode ? if_rd.m_cmd_data_o  : if_wr.m_cmd_data_o;
   assign o_src_tready  = mode ? if_rd.src_tready_o  : if_wr.src_tready_o;
   assign o_dst_tvalid  = mode ? if_rd.dst_tvalid_o  : if_wr.dst_tvalid_o;
   assign o_dst_tdata   = mode ? if_rd.dst_tdata_o   : if_wr.dst_tdata_o;
   assign o_dst_tkeep   = mode ? if_rd.dst_tkeep_o   : if_wr.dst_tkeep_o;
   assign o_dst_tlast   = mode ? if_rd.dst_tlast_o   : if_wr.dst_tlast_o;
   assign o_err_cnt     = mode ? err_cnt_rd          : err_cnt_wr;
   assign o_lm          = mode ? lm_rd               : lm_wr;

   int tests = 0;
   int fails = 0;

   task automatic check(input string tag, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   // Reference model: what the gate must emit, per command, in order
   cmd_t                cmd_q[$];
   beat_t               src_q[$];
   beat_t               dst_q[$];
   logic [DM_CMD_W-1:0] mcmd_q[$];
   int                  exp_err = 0;
   logic                exp_lm  = 1'b0;

   function automatic logic [DATA_W-1:0] rand_data();
      logic [DATA_W-1:0] d;
      for (int i = 0; i < DATA_W / 32; i++) d[i*32 +: 32] = $urandom;
      return d;
   endfunction

   function automatic logic [BYTES-1:0] tail_keep(input int btt);
      logic [BYTES-1:0] k;
      int r;
      r = btt % BYTES;
      if (r == 0) return '1;
      k = '0;
      for (int i = 0; i < r; i++) k[i] = 1'b1;
      return k;
   endfunction

   task automatic add_cmd(input logic err, input int btt, input logic [63:0] addr, input int inj);
      cmd_t  c;
      beat_t b;
      int    nb;
      logic  fin;
      c.err  = err;
      c.bad  = err || (btt == 0);
      c.data = {8'h00, addr, 1'b0, 1'b1, 6'd0, 1'b1, 23'(btt)};
      cmd_q.push_back(c);
      if (!c.bad) mcmd_q.push_back(c.data);
      else exp_err++;
      nb = (btt + BYTES - 1) / BYTES;
      for (int k = 0; k < nb; k++) begin
         fin = (k == nb - 1);
         if (!c.bad || !mode) begin
            b.data = rand_data();
            b.keep = {$urandom, $urandom};
            b.last = fin ^ (k == inj);
            if (k == inj) exp_lm = 1'b1;
            src_q.push_back(b);
            if (!c.bad) begin
               b.last = fin;
               dst_q.push_back(b);
            end
         end else begin
            b.data = '0;
            b.keep = fin ? tail_keep(btt) : '1;
            b.last = fin;
            dst_q.push_back(b);
         end
      end
   endtask

   task automatic idle_inputs();
      cmd_valid   = 1'b0;
      err_st      = 1'b0;
      src_tvalid  = 1'b0;
      src_tlast   = 1'b0;
      m_cmd_ready = 1'b0;
      dst_tready  = 1'b0;
   endtask

   task automatic clear_model();
      cmd_q.delete();
      src_q.delete();
      dst_q.delete();
      mcmd_q.delete();
      exp_err = 0;
      exp_lm  = 1'b0;
   endtask

   task automatic check_reset_vals();
      check("rst_m_cmd_valid", 512'(o_m_cmd_valid), 512'(0));
      check("rst_dst_tvalid", 512'(o_dst_tvalid), 512'(0));
      check("rst_src_tready", 512'(o_src_tready), 512'(0));
      check("rst_err_cnt", 512'(o_err_cnt), 512'(0));
      check("rst_len_mismatch", 512'(o_lm), 512'(0));
      check("rst_cmd_ready", 512'(o_cmd_ready), 512'(1));
   endtask

   task automatic do_reset(input logic m);
      @(negedge clk);
      mode = m;
      rst  = 1'b1;
      idle_inputs();
      clear_model();
      repeat (2) @(negedge clk);
      rst = 1'b0;
      #1;
      check_reset_vals();
   endtask

   // One cycle per iteration: drive at negedge, sample 1ns later, the edge commits.
   task automatic run_traffic(input int budget, input int p_cmd, input int p_src, input int p_mr,
                              input int p_dr, input int mcmd_hold, input int data_hold,
                              input int stop_dst, input int probe);
      int                  cyc = 0, ndst = 0, acc = 0;
      logic                lat_pend = 1'b0, lat_good = 1'b0;
      logic [DM_CMD_W-1:0] lat_data = '0;
      logic                cmd_done = 1'b0, src_done = 1'b0;
      beat_t               b;
      idle_inputs();
      while (cyc < budget && (cmd_q.size() > 0 || src_q.size() > 0 || dst_q.size() > 0 ||
             mcmd_q.size() > 0 || cmd_valid || src_tvalid || lat_pend)) begin
         @(negedge clk);
         if (cmd_done) cmd_valid = 1'b0;
         if (src_done) src_tvalid = 1'b0;
         cmd_done = 1'b0;
         src_done = 1'b0;
         if (!cmd_valid && cmd_q.size() > 0 && $urandom_range(99) < p_cmd) begin
            cmd_valid = 1'b1;
            err_st    = cmd_q[0].err;
            cmd_data  = cmd_q[0].data;
         end
         if (!src_tvalid && src_q.size() > 0 && cyc >= data_hold && $urandom_range(99) < p_src) begin
            src_tvalid = 1'b1;
            src_tdata  = src_q[0].data;
            src_tkeep  = src_q[0].keep;
            src_tlast  = src_q[0].last;
         end
         m_cmd_ready = (cyc >= mcmd_hold) && ($urandom_range(99) < p_mr);
         dst_tready  = (cyc >= data_hold) && ($urandom_range(99) < p_dr);
         #1;
         if (lat_pend) begin
            check("mcmd_latency_valid", 512'(o_m_cmd_valid), 512'(lat_good));
            if (lat_good) check("mcmd_latency_data", 512'(o_m_cmd_data), 512'(lat_data));
            lat_pend = 1'b0;
         end
         if (o_m_cmd_valid && !m_cmd_ready) check("cmd_ready_backpressure", 512'(o_cmd_ready), 512'(0));
         if (cmd_valid && o_cmd_ready) begin
            lat_pend = 1'b1;
            lat_good = !cmd_q[0].bad;
            lat_data = cmd_data;
            void'(cmd_q.pop_front());
            cmd_done = 1'b1;
            acc++;
         end
         if (o_m_cmd_valid && m_cmd_ready) begin
            if (mcmd_q.size() == 0) check("mcmd_unexpected", 512'(1), 512'(0));
            else check("mcmd_data", 512'(o_m_cmd_data), 512'(mcmd_q.pop_front()));
         end
         if (src_tvalid && o_src_tready) begin
            void'(src_q.pop_front());
            src_done = 1'b1;
         end
         if (o_dst_tvalid && dst_tready) begin
            if (dst_q.size() == 0) begin
               check("dst_unexpected", 512'(1), 512'(0));
            end else begin
               b = dst_q.pop_front();
               check("dst_tdata", o_dst_tdata, b.data);
               check("dst_tkeep", 512'(o_dst_tkeep), 512'(b.keep));
               check("dst_tlast", 512'(o_dst_tlast), 512'(b.last));
            end
            ndst++;
         end
         if (cyc == probe) begin
            check("fifo_fill_count", 512'(acc), 512'(4));
            check("fifo_full_ready", 512'(o_cmd_ready), 512'(0));
         end
         cyc++;
         if (stop_dst > 0 && ndst >= stop_dst) break;
      end
      if (stop_dst == 0)
         check("drain_leftover", 512'(cmd_q.size() + src_q.size() + dst_q.size() + mcmd_q.size()), 512'(0));
   endtask

   task automatic settle_and_check();
      @(negedge clk);
      idle_inputs();
      repeat (3) @(negedge clk);
      #1;
      check("err_cnt", 512'(o_err_cnt), 512'(16'(exp_err)));
      check("len_mismatch", 512'(o_lm), 512'(exp_lm));
      check("idle_dst_tvalid", 512'(o_dst_tvalid), 512'(0));
   endtask

   initial begin
      idle_inputs();

      // Good command passes through, READ=1
      do_reset(1'b1);
      add_cmd(1'b0, 100, 64'h1000, -1);
      run_traffic(200, 100, 100, 100, 100, 0, 0, 0, -1);
      settle_and_check();

      // Errored command synthesises zero beats, READ=1
      do_reset(1'b1);
      add_cmd(1'b1, 130, 64'h2000, -1);
      run_traffic(200, 100, 100, 100, 100, 0, 0, 0, -1);
      settle_and_check();

      // Errored command drains stack payload, READ=0
      do_reset(1'b0);
      add_cmd(1'b1, 64, 64'h3000, -1);
      run_traffic(200, 100, 100, 100, 100, 0, 0, 0, -1);
      settle_and_check();

      // DataMover stalled for 6 cycles; ordering of good/err mix
      do_reset(1'b1);
      add_cmd(1'b0, 100, 64'h4000, -1);
      add_cmd(1'b1, 130, 64'h4100, -1);
      add_cmd(1'b0, 64, 64'h4200, -1);
      add_cmd(1'b0, 1, 64'h4300, -1);
      add_cmd(1'b0, 200, 64'h4400, -1);
      run_traffic(400, 100, 100, 100, 100, 6, 0, 0, -1);
      settle_and_check();

      // Payload stalled: meta FIFO fills at 4 entries
      do_reset(1'b1);
      add_cmd(1'b0, 100, 64'h5000, -1);
      add_cmd(1'b1, 130, 64'h5100, -1);
      add_cmd(1'b0, 64, 64'h5200, -1);
      add_cmd(1'b0, 1, 64'h5300, -1);
      add_cmd(1'b0, 200, 64'h5400, -1);
      run_traffic(400, 100, 100, 100, 100, 0, 20, 0, 10);
      settle_and_check();

      // Early src_tlast sets the sticky mismatch flag; it survives a clean command
      do_reset(1'b1);
      add_cmd(1'b0, 128, 64'h6000, 0);
      run_traffic(200, 100, 100, 100, 100, 0, 0, 0, -1);
      settle_and_check();
      add_cmd(1'b0, 64, 64'h6100, -1);
      run_traffic(200, 100, 100, 100, 100, 0, 0, 0, -1);
      settle_and_check();

      // Reset in the middle of a zero-fill burst, then a fresh command
      do_reset(1'b1);
      add_cmd(1'b1, 130, 64'h7000, -1);
      run_traffic(200, 100, 100, 100, 100, 0, 0, 1, -1);
      @(negedge clk);
      #1;
      check("mid_err_dst_tvalid", 512'(o_dst_tvalid), 512'(1));
      rst = 1'b1;
      idle_inputs();
      @(negedge clk);
      rst = 1'b0;
      #1;
      check_reset_vals();
      clear_model();
      add_cmd(1'b0, 65, 64'h7100, -1);
      run_traffic(200, 100, 100, 100, 100, 0, 0, 0, -1);
      settle_and_check();

      // Randomised mixes on both directions
      for (int m = 1; m >= 0; m--) begin
         do_reset(m[0]);
         for (int i = 0; i < 40; i++) begin
            int   btt;
            int   inj;
            logic err;
            err = ($urandom_range(3) == 0);
            case ($urandom_range(5))
               0:       btt = 0;
               1:       btt = 1;
               2:       btt = 64;
               3:       btt = 65;
               4:       btt = 128;
               default: btt = int'($urandom_range(300, 1));
            endcase
            inj = ($urandom_range(9) == 0) ? int'($urandom_range(3)) : -1;
            add_cmd(err, btt, {32'h0, $urandom}, inj);
         end
         run_traffic(20000, 70, 70, 60, 60, 0, 0, 0, -1);
         settle_and_check();
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
